// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus tap: decodes START/ADDR/DATA/ACK/STOP into byte records in a FWFT FIFO.
// Define I2C_MON_TIMESTAMP_EN to add a 16-bit cycle timestamp to each record (rec_time_o).
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        rec_valid_o,
    input  logic        rec_ready_i,
    output logic [1:0]  rec_kind_o,
    output logic [7:0]  rec_data_o,
    output logic        rec_ack_o,
    output logic        rec_rnw_o,
    output logic        bus_busy_o,
    output logic        overflow_o,
`ifdef I2C_MON_TIMESTAMP_EN
    output logic [15:0] rec_time_o,
`endif
    input  logic        ovf_clr_i
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BASE_W = 12;
`ifdef I2C_MON_TIMESTAMP_EN
    localparam int REC_W  = BASE_W + 16;
`else
    localparam int REC_W  = BASE_W;
`endif
    localparam logic [1:0]     K_ADDR  = 2'd0;
    localparam logic [1:0]     K_DATA  = 2'd1;
    localparam logic [1:0]     K_STOP  = 2'd2;
    localparam logic [1:0]     K_ERR   = 2'd3;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, DATA, ACK_D} state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic                   scl_s, sda_s, start_det, stop_det, scl_rise, scl_fall;

    state_t              state_q, state_d;
    logic [3:0]          bitcnt_q, bitcnt_d, eff_cnt;
    logic [7:0]          shreg_q, shreg_d;
    logic                rnw_q, rnw_d, first_open_q, first_open_d;
    logic                pend_stop_q, pend_stop_d, push_q, push_d;
    logic [BASE_W-1:0]   rec_q, rec_d;

    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                ovf_q, ovf_d, empty, full, pop, wr_en, drop;
    logic [REC_W-1:0]    mem_q [FIFO_DEPTH];
    logic [REC_W-1:0]    wr_rec, head;
`ifdef I2C_MON_TIMESTAMP_EN
    logic [15:0]         time_q, time_d;
`endif

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_hist_d = scl_s;
        sda_hist_d = sda_s;
        start_det  = scl_s && scl_hist_q && sda_hist_q && !sda_s;
        stop_det   = scl_s && scl_hist_q && !sda_hist_q && sda_s;
        scl_rise   = scl_s && !scl_hist_q;
        scl_fall   = !scl_s && scl_hist_q;
    end

    // The SCL rise just before a STOP or repeated START looks like a first data bit;
    // while SCL is still high after that rise it is not counted as part of a byte.
    assign eff_cnt = (first_open_q && bitcnt_q == 4'd1) ? 4'd0 : bitcnt_q;

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        rnw_d        = rnw_q;
        first_open_d = first_open_q;
        pend_stop_d  = 1'b0;
        push_d       = 1'b0;
        rec_d        = '0;
        if (scl_fall) first_open_d = 1'b0;
        if (start_det) begin
            if (state_q != IDLE && eff_cnt != 4'd0) begin
                push_d = 1'b1;
                rec_d  = {K_ERR, 8'h00, 1'b0, rnw_q};
            end
            state_d      = ADDR;
            bitcnt_d     = 4'd0;
            first_open_d = 1'b0;
        end else if (stop_det) begin
            if (state_q != IDLE) begin
                push_d = 1'b1;
                if (eff_cnt == 4'd0) begin
                    rec_d = {K_STOP, 8'h00, 1'b0, rnw_q};
                end else begin
                    rec_d       = {K_ERR, 8'h00, 1'b0, rnw_q};
                    pend_stop_d = 1'b1;
                end
                state_d      = IDLE;
                bitcnt_d     = 4'd0;
                first_open_d = 1'b0;
            end
        end else if (scl_rise) begin
            case (state_q)
                ADDR, DATA: begin
                    shreg_d      = {shreg_q[6:0], sda_s};
                    bitcnt_d     = bitcnt_q + 4'd1;
                    first_open_d = (bitcnt_q == 4'd0);
                    if (bitcnt_q == 4'd7) state_d = (state_q == ADDR) ? ACK_A : ACK_D;
                end
                ACK_A: begin
                    push_d   = 1'b1;
                    rec_d    = {K_ADDR, shreg_q, !sda_s, shreg_q[0]};
                    rnw_d    = shreg_q[0];
                    bitcnt_d = 4'd0;
                    state_d  = DATA;
                end
                ACK_D: begin
                    push_d   = 1'b1;
                    rec_d    = {K_DATA, shreg_q, !sda_s, rnw_q};
                    bitcnt_d = 4'd0;
                    state_d  = DATA;
                end
                default: ;
            endcase
        end
        if (pend_stop_q) begin
            push_d = 1'b1;
            rec_d  = {K_STOP, 8'h00, 1'b0, rnw_q};
        end
    end

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop      = !empty && rec_ready_i;
        wr_en    = push_q && (!full || pop);
        drop     = push_q && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ovf_d    = (ovf_q && !ovf_clr_i) || drop;
`ifdef I2C_MON_TIMESTAMP_EN
        time_d   = time_q + 16'd1;
        wr_rec   = {time_q, rec_q};
`else
        wr_rec   = rec_q;
`endif
        head     = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q   <= '0;
            sda_sync_q   <= '0;
            scl_hist_q   <= 1'b0;
            sda_hist_q   <= 1'b0;
            state_q      <= IDLE;
            bitcnt_q     <= 4'd0;
            shreg_q      <= 8'h00;
            rnw_q        <= 1'b0;
            first_open_q <= 1'b0;
            pend_stop_q  <= 1'b0;
            push_q       <= 1'b0;
            rec_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ovf_q        <= 1'b0;
`ifdef I2C_MON_TIMESTAMP_EN
            time_q       <= 16'd0;
`endif
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_hist_q   <= scl_hist_d;
            sda_hist_q   <= sda_hist_d;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            rnw_q        <= rnw_d;
            first_open_q <= first_open_d;
            pend_stop_q  <= pend_stop_d;
            push_q       <= push_d;
            rec_q        <= rec_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_q        <= ovf_d;
`ifdef I2C_MON_TIMESTAMP_EN
            time_q       <= time_d;
`endif
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_rec;
    end

    assign rec_valid_o = !empty;
    assign {rec_kind_o, rec_data_o, rec_ack_o, rec_rnw_o} = empty ? '0 : head[BASE_W-1:0];
`ifdef I2C_MON_TIMESTAMP_EN
    assign rec_time_o  = empty ? 16'h0000 : head[REC_W-1:BASE_W];
`endif
    assign bus_busy_o  = (state_q != IDLE);
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: bit-banged I2C transfers, record scoreboard, FIFO corner cases.
module tb_i2c_bus_monitor;
    localparam int Q = 5;
    localparam logic [1:0] K_ADDR = 2'd0;
    localparam logic [1:0] K_DATA = 2'd1;
    localparam logic [1:0] K_STOP = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    logic       clk = 1'b0;
    logic       rst, scl, sda, rec_ready, ovf_clr;
    logic       rec_valid, rec_ack, rec_rnw, bus_busy, overflow;
    logic [1:0] rec_kind;
    logic [7:0] rec_data;
`ifdef I2C_MON_TIMESTAMP_EN
    logic [15:0] rec_time;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [11:0] exp_q[$];
    logic        model_rnw = 1'b0;
    logic        busy_watch = 1'b0;
    logic        busy_drop = 1'b0;

    i2c_bus_monitor #(.SYNC_STAGES(2), .FIFO_DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda),
        .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
        .rec_kind_o(rec_kind), .rec_data_o(rec_data),
        .rec_ack_o(rec_ack), .rec_rnw_o(rec_rnw),
        .bus_busy_o(bus_busy), .overflow_o(overflow),
`ifdef I2C_MON_TIMESTAMP_EN
        .rec_time_o(rec_time),
`endif
        .ovf_clr_i(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] mk(input logic [1:0] k, input logic [7:0] d,
                                       input logic a, input logic r);
        return {k, d, a, r};
    endfunction

    // Scoreboard: every accepted record is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL rec_extra: got %h expected none", {rec_kind, rec_data, rec_ack, rec_rnw});
            end else begin
                check("rec", 32'({rec_kind, rec_data, rec_ack, rec_rnw}), 32'(exp_q.pop_front()));
            end
        end
        if (busy_watch && !bus_busy) busy_drop = 1'b1;
    end

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_bit(input logic b);
        sda = b;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        scl = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_start();
        sda = 1'b0;
        cyc(Q);
        scl = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_rep_start();
        sda = 1'b1;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        sda = 1'b0;
        cyc(Q);
        scl = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_stop(input logic err, input logic keep);
        if (keep) begin
            if (err) exp_q.push_back(mk(K_ERR, 8'h00, 1'b0, model_rnw));
            exp_q.push_back(mk(K_STOP, 8'h00, 1'b0, model_rnw));
        end
        sda = 1'b0;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        sda = 1'b1;
        cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack, input logic is_addr,
                             input logic keep);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        if (is_addr) model_rnw = b[0];
        if (keep) exp_q.push_back(mk(is_addr ? K_ADDR : K_DATA, b, ack, model_rnw));
        i2c_bit(!ack);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) cyc(1);
        cyc(10);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] b9;
        rst = 1'b1; scl = 1'b1; sda = 1'b1; rec_ready = 1'b1; ovf_clr = 1'b0;
        cyc(3);
        check("rst_valid", 32'(rec_valid), 32'd0);
        check("rst_busy", 32'(bus_busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_rec", 32'({rec_kind, rec_data, rec_ack, rec_rnw}), 32'd0);
        rst = 1'b0;
        cyc(5);

        // Write 0x22, 0xA5, STOP
        i2c_start();
        check("t1_busy_start", 32'(bus_busy), 32'd1);
        send_byte(8'h44, 1'b1, 1'b1, 1'b1);
        send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
        i2c_stop(1'b0, 1'b1);
        check("t1_busy_stop", 32'(bus_busy), 32'd0);
        wait_drain("t1_drain");

        // Read 0x22, 0x3C ACK, 0xF0 NACK
        i2c_start();
        send_byte(8'h45, 1'b1, 1'b1, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b0, 1'b0, 1'b1);
        i2c_stop(1'b0, 1'b1);
        wait_drain("t2_drain");

        // Repeated START between write and read
        i2c_start();
        busy_watch = 1'b1;
        send_byte(8'h44, 1'b1, 1'b1, 1'b1);
        send_byte(8'h11, 1'b1, 1'b0, 1'b1);
        i2c_rep_start();
        send_byte(8'h45, 1'b1, 1'b1, 1'b1);
        send_byte(8'h77, 1'b0, 1'b0, 1'b1);
        busy_watch = 1'b0;
        check("t3_busy_held", 32'(busy_drop), 32'd0);
        i2c_stop(1'b0, 1'b1);
        wait_drain("t3_drain");

        // STOP after 3 bits of a data byte
        i2c_start();
        send_byte(8'h44, 1'b1, 1'b1, 1'b1);
        i2c_bit(1'b1);
        i2c_bit(1'b0);
        i2c_bit(1'b1);
        i2c_stop(1'b1, 1'b1);
        check("t4_idle", 32'(bus_busy), 32'd0);
        wait_drain("t4_drain");

        // Overflow: 10 records into 8 entries, last two dropped
        rec_ready = 1'b0;
        i2c_start();
        send_byte(8'h44, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 9; i++) send_byte(8'(i * 17), 1'b1, 1'b0, i <= 7);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_valid", 32'(rec_valid), 32'd1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        rec_ready = 1'b1;
        wait_drain("ovf_drain");
        i2c_stop(1'b0, 1'b1);
        wait_drain("ovf_stop_drain");

        // Full FIFO: push and pop in the same cycle both succeed
        rec_ready = 1'b0;
        i2c_start();
        send_byte(8'h44, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) send_byte(8'(8'hC0 + i), 1'b1, 1'b0, 1'b1);
        b9 = 8'h96;
        for (int i = 7; i >= 0; i--) i2c_bit(b9[i]);
        exp_q.push_back(mk(K_DATA, b9, 1'b1, model_rnw));
        sda = 1'b0;
        cyc(Q);
        scl = 1'b1;
        cyc(3);
        rec_ready = 1'b1;
        cyc(1);
        rec_ready = 1'b0;
        cyc(1);
        scl = 1'b0;
        cyc(Q);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        check("full_pushpop_cnt", 32'(exp_q.size()), 32'd8);
        rec_ready = 1'b1;
        wait_drain("full_drain");
        i2c_stop(1'b0, 1'b1);
        wait_drain("full_stop_drain");

        // Reset mid-byte with a non-empty FIFO and overflow set
        rec_ready = 1'b0;
        i2c_start();
        send_byte(8'h44, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, 1'b0, 1'b0);
        check("rst_pre_ovf", 32'(overflow), 32'd1);
        i2c_bit(1'b1);
        i2c_bit(1'b1);
        i2c_bit(1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(rec_valid), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        check("rst_mid_busy", 32'(bus_busy), 32'd0);
        exp_q.delete();
        model_rnw = 1'b0;
        cyc(1);
        rst = 1'b0;
        rec_ready = 1'b1;
        for (int i = 0; i < 6; i++) i2c_bit(1'($urandom_range(0, 1)));
        i2c_stop(1'b0, 1'b0);
        cyc(10);
        check("rst_no_rec", 32'(rec_valid), 32'd0);
        check("rst_no_busy", 32'(bus_busy), 32'd0);

        // Recovery after reset needs a fresh START
        i2c_start();
        send_byte(8'h44, 1'b1, 1'b1, 1'b1);
        send_byte(8'h5A, 1'b0, 1'b0, 1'b1);
        i2c_stop(1'b0, 1'b1);
        wait_drain("post_rst_drain");
        check("end_ovf", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
- Passive RTL tap on one I2C bus (SCL/SDA) of the I2CMB DUT.
- Decodes START, address, data, ACK and STOP into byte-level records and buffers them in a FIFO.
- The bench's I2C monitor, predictor and scoreboard drain the FIFO over a valid/ready handshake.
- Never drives the bus.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on scl_i/sda_i; legal range 2..4.
- FIFO_DEPTH, 8, record FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- scl_i  in  1  raw bus SCL, asynchronous.
- sda_i  in  1  raw bus SDA, asynchronous.
- rec_valid_o  out  1  FIFO head holds a record.
- rec_ready_i  in  1  consumer accepts the head record.
- rec_kind_o  out  2  0=ADDR byte, 1=DATA byte, 2=STOP, 3=ERROR (truncated byte).
- rec_data_o  out  8  byte value, MSB-first order on the bus; 0 for STOP/ERROR.
- rec_ack_o  out  1  1 when the 9th bit was sampled low; 0 for STOP/ERROR.
- rec_rnw_o  out  1  R/W bit of the most recent ADDR byte in this transfer.
- bus_busy_o  out  1  high from START detect until STOP detect.
- overflow_o  out  1  sticky; set when a record is dropped on a full FIFO.
- ovf_clr_i  in  1  synchronous clear of overflow_o.

Behaviour:
- Reset: all outputs 0. FSM in IDLE, FIFO empty, bit counter 0.
- Synchronisation: SYNC_STAGES flops per line, then one history register. Edges are evaluated on synchronised values only.
- START: SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. A data bit is sampled on each SCL 0->1 edge.
- FSM states: IDLE, ADDR, ACK_A, DATA, ACK_D.
  - IDLE --START--> ADDR.
  - ADDR: after 8 bits --> ACK_A.
  - ACK_A: 9th bit sampled, push ADDR record, latch rnw=data[0] --> DATA.
  - DATA: after 8 bits --> ACK_D.
  - ACK_D: 9th bit sampled, push DATA record --> DATA.
- Bit counter: 0..8, reset to 0 on every START and STOP and after each ACK bit.
- STOP in any non-IDLE state:
  - bit counter 0: push STOP record --> IDLE.
  - bit counter 1..8: push ERROR, then STOP on the following cycle --> IDLE.
- Repeated START in any non-IDLE state:
  - bit counter 1..8: push ERROR first.
  - Then --> ADDR with bus_busy_o held high. rnw is retained until the new ADDR record.
- START and STOP are never seen in the same cycle. A STOP while in IDLE is ignored.
- Latency: a record is written to the FIFO the cycle after the synchronised SCL rise that completes it. rec_valid_o rises the cycle after that.
- FIFO:
  - First-word-fall-through; outputs reflect the head entry.
  - Pop when rec_valid_o && rec_ready_i.
  - Pointers are log2(FIFO_DEPTH)+1 bits with natural wrap.
  - Push while full with no pop in the same cycle: record dropped, overflow_o set.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty: no effect.
  - ovf_clr_i and a new overflow in the same cycle: overflow_o stays set.
- Reset asserted mid-transfer: FIFO flushed, FSM to IDLE. The first record after reset requires a new START.

Optional Feature:
- I2C_MON_TIMESTAMP_EN defined:
  - Adds output port rec_time_o[15:0] and a free-running 16-bit cycle counter, reset to 0, wrapping at 0xFFFF->0x0000.
  - Each record stores the counter value from its push cycle.
- Undefined: no port, no counter; record width is 12 bits.

Test Plan:
- Write to 0x22, data 0xA5, ACK on both, STOP -> records ADDR/0x44/ack=1/rnw=0, DATA/0xA5/ack=1/rnw=0, STOP. bus_busy_o 1 from START to STOP.
- Read from 0x22, two bytes 0x3C (ACK) and 0xF0 (NACK), STOP -> ADDR/0x45/rnw=1, DATA/0x3C/ack=1, DATA/0xF0/ack=0, STOP.
- Write 0x22, 0x11, repeated START, read 0x22, byte 0x77, STOP -> ADDR 0x44, DATA 0x11, ADDR 0x45/rnw=1, DATA 0x77, STOP; bus_busy_o never drops.
- STOP after 3 bits of a data byte -> ERROR record, then STOP record; FSM in IDLE.
- rec_ready_i=0, 10 bytes written with FIFO_DEPTH=8 -> 8 records retained in order, overflow_o=1. ovf_clr_i pulse -> overflow_o=0. Full push and pop in the same cycle -> no overflow.
- rst_i asserted for 1 cycle mid-byte -> rec_valid_o=0 and overflow_o=0 immediately; bits before the next START produce no records.
